// File: rtl/ahb3_ram_responder.sv
// ahb3_ram_responder: AHB-Lite slave on a word-organised RAM with programmable wait states,
// same-word write-to-read bypass and a two-cycle ERROR response for illegal transfers.
module ahb3_ram_responder #(
  parameter int HADDR_SIZE  = 32,
  parameter int HDATA_SIZE  = 32,
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_LAST = 3'd2, S_ERR1 = 3'd3, S_ERR2 = 3'd4;
  logic [2:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [3:0]            be_q, be_d;
  logic [AW-1:0]         idx_q, rd_idx;
  logic                  wr_q, hready_q, hresp_q;
  logic                  accept, illegal, commit, unused;
  logic [HDATA_SIZE-1:0] rdata_q, rdata_d;
  logic [HDATA_SIZE-1:0] mem [MEM_WORDS];
  assign unused  = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};
  assign accept  = HSEL & HREADY & HTRANS[1];
  assign illegal = (HSIZE > 3'd2) || (HSIZE == 3'd1 && HADDR[0]) || (HSIZE == 3'd2 && HADDR[1:0] != 2'd0)
                   || (HADDR >= HADDR_SIZE'(4 * MEM_WORDS));
  assign be_d    = HSIZE == 3'd0 ? 4'b0001 << HADDR[1:0] : HSIZE == 3'd1 ? (HADDR[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign rd_idx  = HADDR[AW+1:2];
  assign commit  = state_q == S_LAST && wr_q;
  assign HRDATA    = rdata_q;
  assign HREADYOUT = hready_q;
  assign HRESP     = hresp_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_WAIT) begin
      cnt_d   = cnt_q - 4'd1;
      state_d = cnt_q == 4'd1 ? S_LAST : S_WAIT;
    end else if (state_q == S_ERR1) begin
      state_d = S_ERR2;
    end else if (accept) begin
      state_d = illegal ? S_ERR1 : WAIT_STATES > 0 ? S_WAIT : S_LAST;
      cnt_d   = 4'(WAIT_STATES);
    end else begin
      state_d = S_IDLE;
    end
  end
  // Bypass: a write committing on the accepting edge overrides its lanes in the read word
  always_comb begin
    rdata_d = mem[rd_idx];
    for (int i = 0; i < 4; i++)
      if (commit && idx_q == rd_idx && be_q[i]) rdata_d[8*i +: 8] = HWDATA[8*i +: 8];
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      wr_q     <= 1'b0;
      be_q     <= 4'd0;
      idx_q    <= '0;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hready_q <= !(state_d == S_WAIT || state_d == S_ERR1);
      hresp_q  <= state_d == S_ERR1 || state_d == S_ERR2;
      if (accept) begin
        wr_q  <= HWRITE && !illegal;
        be_q  <= be_d;
        idx_q <= rd_idx;
      end else if (state_q == S_LAST) begin
        wr_q <= 1'b0;
      end
      if (accept && !illegal && !HWRITE) rdata_q <= rdata_d;
    end
  end
  always_ff @(posedge HCLK) begin
    if (commit)
      for (int i = 0; i < 4; i++)
        if (be_q[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
  end
endmodule

// File: tb/tb_ahb3_ram_responder.sv
// tb_ahb3_ram_responder: directed checks of a zero-wait and a two-wait-state responder sharing one bus.
module tb_ahb3_ram_responder;
  logic        HCLK = 0, HRESETn = 0, HSEL = 0, HWRITE = 0, HMASTLOCK = 0, which = 0;
  logic [31:0] HADDR = 0, HWDATA = 0;
  logic [2:0]  HSIZE = 0, HBURST = 0;
  logic [3:0]  HPROT = 0;
  logic [1:0]  HTRANS = 0;
  logic [31:0] rd0, rd2, hrdata;
  logic        ro0, ro2, rs0, rs2, hreadyout, hresp;
  int          n_chk = 0, n_err = 0;
  logic [31:0] err_addr [4] = '{32'h1, 32'h2, 32'h0, 32'h1000};
  logic [2:0]  err_size [4] = '{3'd1, 3'd2, 3'd3, 3'd2};

  always #5 HCLK = ~HCLK;
  assign hreadyout = which ? ro2 : ro0;
  assign hresp     = which ? rs2 : rs0;
  assign hrdata    = which ? rd2 : rd0;

  ahb3_ram_responder #(.WAIT_STATES(0)) u_ws0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL & !which), .HADDR(HADDR), .HWDATA(HWDATA),
    .HRDATA(rd0), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(hreadyout), .HREADYOUT(ro0), .HRESP(rs0));
  ahb3_ram_responder #(.WAIT_STATES(2)) u_ws2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL & which), .HADDR(HADDR), .HWDATA(HWDATA),
    .HRDATA(rd2), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(hreadyout), .HREADYOUT(ro2), .HRESP(rs2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Single NONSEQ transfer; returns read data, HREADYOUT-low cycles and HRESP-high cycles
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd,
                      output logic [31:0] rd, output int waits, output int resps);
    bit done;
    done = 0;
    HSEL = 1; HTRANS = 2'b10; HWRITE = wr; HADDR = a; HSIZE = sz;
    @(posedge HCLK); #1;
    HSEL = 0; HTRANS = 2'b00; HWDATA = wd;
    waits = 0; resps = 0; rd = 'x;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge HCLK);
      resps += hresp ? 1 : 0;
      if (hreadyout) begin rd = hrdata; done = 1; end
      else waits++;
    end
    if (!done) chk("xfer_timeout", 32'd0, 32'd1);
    @(posedge HCLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int w, r, cyc, done_beats, beat;
    repeat (3) @(posedge HCLK); #1;
    chk("rst_ready", hreadyout, 1); chk("rst_resp", hresp, 0); chk("rst_rdata", hrdata, 0);
    HRESETn = 1; HSEL = 1; HTRANS = 2'b00;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    chk("idle_ready", hreadyout, 1); chk("idle_resp", hresp, 0);
    @(posedge HCLK); #1; HSEL = 0;
    // back-to-back write then read of the same word, zero wait
    HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = 32'h10; HSIZE = 3'd2;
    @(posedge HCLK); #1;
    HWDATA = 32'hDEADBEEF; HWRITE = 0;
    @(negedge HCLK); chk("b2b_wr_ready", hreadyout, 1);
    @(posedge HCLK); #1; HSEL = 0; HTRANS = 2'b00;
    @(negedge HCLK); chk("b2b_rd_ready", hreadyout, 1); chk("b2b_bypass", hrdata, 32'hDEADBEEF);
    @(posedge HCLK); #1;
    xfer(0, 32'h10, 3'd2, 0, d, w, r); chk("ram_10", d, 32'hDEADBEEF); chk("ws0_wait", w, 0);
    // byte and halfword lanes
    xfer(1, 32'h20, 3'd2, 32'h11223344, d, w, r);
    xfer(1, 32'h21, 3'd0, 32'h0000AA00, d, w, r);
    xfer(1, 32'h22, 3'd1, 32'hBBCC0000, d, w, r);
    xfer(0, 32'h20, 3'd2, 0, d, w, r); chk("lanes", d, 32'hBBCCAA44);
    // illegal transfers must error for two cycles and leave word 0 intact
    xfer(1, 32'h0, 3'd2, 32'hCAFEF00D, d, w, r);
    for (int i = 0; i < 4; i++) begin
      xfer(1, err_addr[i], err_size[i], 32'hFFFFFFFF, d, w, r);
      chk("err_wait", w, 1); chk("err_resp", r, 2);
    end
    xfer(0, 32'h0, 3'd2, 0, d, w, r);
    chk("err_ram", d, 32'hCAFEF00D); chk("post_err_resp", r, 0);
    // two wait states
    which = 1;
    for (int i = 0; i < 4; i++) begin
      xfer(1, 32'h40 + 32'(4 * i), 3'd2, 32'hA0000000 + 32'(i), d, w, r);
      if (i == 0) chk("ws2_wr_wait", w, 2);
    end
    xfer(0, 32'h44, 3'd2, 0, d, w, r); chk("ws2_rd_wait", w, 2); chk("ws2_rd_data", d, 32'hA0000001);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HSIZE = 3'd2; HBURST = 3'b011; HADDR = 32'h40;
    @(posedge HCLK); #1;
    beat = 1; done_beats = 0; cyc = 0;
    while (done_beats < 4 && cyc < 40) begin
      HTRANS = beat < 4 ? 2'b11 : 2'b00; HSEL = beat < 4; HADDR = 32'h40 + 32'(4 * beat);
      @(negedge HCLK); cyc++;
      if (hreadyout) begin
        chk("burst_data", hrdata, 32'hA0000000 + 32'(done_beats));
        done_beats++;
        if (beat < 4) beat++;
      end
      @(posedge HCLK); #1;
    end
    chk("burst_cycles", cyc, 12);
    HBURST = 0; HSEL = 0; HTRANS = 2'b00;
    xfer(1, 32'h2, 3'd2, 32'hFFFFFFFF, d, w, r); chk("ws2_err_wait", w, 1); chk("ws2_err_resp", r, 2);
    // reset during the wait states of a write
    xfer(1, 32'h30, 3'd2, 32'h12345678, d, w, r);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = 32'h30; HSIZE = 3'd2;
    @(posedge HCLK); #1;
    HSEL = 0; HTRANS = 2'b00; HWDATA = 32'hFFFFFFFF;
    @(negedge HCLK); chk("mid_wait_ready", hreadyout, 0);
    HRESETn = 0; #1;
    chk("async_rst_ready", hreadyout, 1); chk("async_rst_resp", hresp, 0); chk("async_rst_rdata", hrdata, 0);
    @(negedge HCLK); HRESETn = 1;
    @(posedge HCLK); #1;
    xfer(0, 32'h30, 3'd2, 0, d, w, r); chk("rst_lost_write", d, 32'h12345678); chk("rst_rd_wait", w, 2);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
